// File: rtl/dcache_pkg.sv
// Shared types, widths and address helpers for the direct-mapped write-back L1 data cache.
// Controller state encoding lives here so the top and any future debug logic agree on it.
package dcache_pkg;

  localparam int WORD_W   = 32;
  localparam int OFFSET_W = 5;
  localparam int LINE_W_C = 256;
  localparam int WOFF_W   = OFFSET_W - 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [WOFF_W-1:0] word_offset(input logic [31:0] addr);
    return addr[OFFSET_W-1:2];
  endfunction

  function automatic logic [31:0] line_base(input logic [31:0] addr);
    return {addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/dirty/tag/data storage: one combinational read port, one write port that either
// fills a whole line (valid=1, dirty=0) or writes one word (dirty=1). Valid/dirty clear on reset.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int LINES   = 32,
  parameter int INDEX_W = 5,
  parameter int LINE_W  = 256,
  parameter int TAG_W   = 32 - INDEX_W - OFFSET_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic               rd_dirty,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [LINE_W-1:0]  rd_data,
  input  logic               wr_en,
  input  logic               wr_fill,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [LINE_W-1:0]  wr_line,
  input  logic [WOFF_W-1:0]  wr_word_sel,
  input  logic [WORD_W-1:0]  wr_word
);

  localparam int WORDS = LINE_W / WORD_W;

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [LINE_W-1:0] data_mem [LINES];
  logic [LINE_W-1:0] merged_line;

  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

  // Single-word store merges into the current line contents.
  always_comb begin
    merged_line = data_mem[wr_index];
    for (int w = 0; w < WORDS; w++) begin
      if (wr_word_sel == w[WOFF_W-1:0]) begin
        merged_line[w*WORD_W +: WORD_W] = wr_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      if (wr_fill) begin
        valid_q[wr_index] <= 1'b1;
        dirty_q[wr_index] <= 1'b0;
      end else begin
        dirty_q[wr_index] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset && wr_en) begin
      if (wr_fill) begin
        tag_mem[wr_index]  <= wr_tag;
        data_mem[wr_index] <= wr_line;
      end else begin
        data_mem[wr_index] <= merged_line;
      end
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// L1 data cache controller (direct-mapped, write-back, write-allocate) with line-wide memory handshake.
// Optional hit/miss counters are built only when DCACHE_PERF_CNT_EN is defined.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINES   = 32,
  parameter int INDEX_W = 5,
  parameter int LINE_W  = LINE_W_C
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  localparam int TAG_W = 32 - INDEX_W - OFFSET_W;
  localparam int WORDS = LINE_W / WORD_W;

  state_t state, state_nxt;

  logic [WOFF_W-1:0]  word_off;
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic               unused_addr_bits;

  logic               rd_valid;
  logic               rd_dirty;
  logic [TAG_W-1:0]   rd_tag;
  logic [LINE_W-1:0]  rd_data;
  logic [WORD_W-1:0]  sel_word;
  logic               hit;
  logic               arr_we;
  logic               arr_fill;

  assign word_off         = word_offset(cpu_addr);
  assign index            = cpu_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
  assign tag              = cpu_addr[31:INDEX_W+OFFSET_W];
  assign unused_addr_bits = ^cpu_addr[1:0];

  dcache_array #(
    .LINES   (LINES),
    .INDEX_W (INDEX_W),
    .LINE_W  (LINE_W),
    .TAG_W   (TAG_W)
  ) u_array (
    .clk         (clk),
    .reset       (reset),
    .rd_index    (index),
    .rd_valid    (rd_valid),
    .rd_dirty    (rd_dirty),
    .rd_tag      (rd_tag),
    .rd_data     (rd_data),
    .wr_en       (arr_we),
    .wr_fill     (arr_fill),
    .wr_index    (index),
    .wr_tag      (tag),
    .wr_line     (mem_rdata),
    .wr_word_sel (word_off),
    .wr_word     (cpu_wdata)
  );

  assign hit = rd_valid && (rd_tag == tag);

  always_comb begin
    sel_word = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (word_off == w[WOFF_W-1:0]) begin
        sel_word = rd_data[w*WORD_W +: WORD_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The stalled pipeline holds cpu_addr, so the array read port keeps presenting the
  // victim line throughout WB and the write-back outputs stay stable without extra flops.
  always_comb begin
    state_nxt = state;
    cpu_stall = 1'b0;
    cpu_rdata = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    arr_we    = 1'b0;
    arr_fill  = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          if (hit) begin
            if (cpu_we) begin
              arr_we = 1'b1;
            end else begin
              cpu_rdata = sel_word;
            end
          end else begin
            cpu_stall = 1'b1;
            state_nxt = (rd_valid && rd_dirty) ? WB : FILL;
          end
        end
      end
      WB: begin
        cpu_stall = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {rd_tag, index, {OFFSET_W{1'b0}}};
        mem_wdata = rd_data;
        if (mem_ack) begin
          state_nxt = FILL;
        end
      end
      FILL: begin
        cpu_stall = 1'b1;
        mem_req   = 1'b1;
        mem_addr  = line_base(cpu_addr);
        if (mem_ack) begin
          arr_we    = 1'b1;
          arr_fill  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        cpu_stall = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (!reset) begin
      cpu_stall = 1'b0;
      cpu_rdata = '0;
      arr_we    = 1'b0;
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_q;
  logic [31:0] miss_q;

  // A replayed access after DONE lands here as a hit, so each miss also yields one hit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (state == IDLE && cpu_req) begin
      if (hit) begin
        hit_q <= hit_q + 32'd1;
      end else begin
        miss_q <= miss_q + 32'd1;
      end
    end
  end

  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: miss/fill/replay, hits, dirty write-back, slow memory, reset abort.
module tb_dcache_ctrl;

`ifdef DCACHE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_req;
  logic         cpu_we;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [31:0]  cpu_rdata;
  logic         cpu_stall;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_ack;
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;

  int checks = 0;
  int errors = 0;

  dcache_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_line(input logic [31:0] base);
    for (int w = 0; w < 8; w++) begin
      mem_rdata[w*32 +: 32] = base + w;
    end
  endtask

  function automatic logic [31:0] cnt_exp(input int n);
    return PERF ? n : 32'd0;
  endfunction

  initial begin
    reset     = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;

    // Reset state
    tick; tick;
    chk("rst_stall", {31'b0, cpu_stall}, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_hit_cnt", hit_cnt, cnt_exp(0));
    chk("rst_miss_cnt", miss_cnt, cnt_exp(0));
    reset = 1'b1;
    tick;

    // Cold miss on 0x40 -> FILL -> DONE -> replay hit
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    #1;
    chk("miss_stall_comb", {31'b0, cpu_stall}, 32'd1);
    chk("miss_idle_no_req", {31'b0, mem_req}, 32'd0);
    tick;
    chk("fill_req", {31'b0, mem_req}, 32'd1);
    chk("fill_we", {31'b0, mem_we}, 32'd0);
    chk("fill_addr", mem_addr, 32'h40);
    chk("fill_stall", {31'b0, cpu_stall}, 32'd1);
    set_line(32'hDEADBEEF);
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    #1;
    chk("done_stall", {31'b0, cpu_stall}, 32'd1);
    chk("done_req_low", {31'b0, mem_req}, 32'd0);
    tick;
    chk("replay_stall", {31'b0, cpu_stall}, 32'd0);
    chk("replay_rdata", cpu_rdata, 32'hDEADBEEF);
    tick;
    cpu_req = 1'b0;
    #1;
    chk("cnt1_hit", hit_cnt, cnt_exp(1));
    chk("cnt1_miss", miss_cnt, cnt_exp(1));

    // Repeat hits
    cpu_req = 1'b1; cpu_addr = 32'h40;
    #1;
    chk("hit40_stall", {31'b0, cpu_stall}, 32'd0);
    chk("hit40_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("hit40_no_req", {31'b0, mem_req}, 32'd0);
    tick;
    cpu_addr = 32'h48;
    #1;
    chk("hit48_rdata", cpu_rdata, 32'hDEADBEF1);
    tick;

    // Store hit then load back
    cpu_we = 1'b1; cpu_addr = 32'h44; cpu_wdata = 32'h12345678;
    #1;
    chk("st44_stall", {31'b0, cpu_stall}, 32'd0);
    tick;
    cpu_we = 1'b0;
    #1;
    chk("ld44_rdata", cpu_rdata, 32'h12345678);
    tick;

    // Conflict miss on dirty line: WB then FILL with 10-cycle ack delay
    cpu_addr = 32'h440;
    #1;
    chk("conf_stall", {31'b0, cpu_stall}, 32'd1);
    tick;
    chk("wb_req", {31'b0, mem_req}, 32'd1);
    chk("wb_we", {31'b0, mem_we}, 32'd1);
    chk("wb_addr", mem_addr, 32'h40);
    chk("wb_w0", mem_wdata[31:0], 32'hDEADBEEF);
    chk("wb_w1", mem_wdata[63:32], 32'h12345678);
    tick; tick;
    chk("wb_hold_addr", mem_addr, 32'h40);
    chk("wb_hold_w1", mem_wdata[63:32], 32'h12345678);
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    #1;
    chk("fill2_we", {31'b0, mem_we}, 32'd0);
    chk("fill2_addr", mem_addr, 32'h440);
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("slow_req", {31'b0, mem_req}, 32'd1);
      chk("slow_addr", mem_addr, 32'h440);
      chk("slow_stall", {31'b0, cpu_stall}, 32'd1);
    end
    set_line(32'hCAFEF00D);
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    #1;
    chk("done2_stall", {31'b0, cpu_stall}, 32'd1);
    tick;
    chk("replay2_stall", {31'b0, cpu_stall}, 32'd0);
    chk("replay2_rdata", cpu_rdata, 32'hCAFEF00D);
    tick;
    cpu_req = 1'b0;
    #1;
    chk("cnt2_hit", hit_cnt, cnt_exp(6));
    chk("cnt2_miss", miss_cnt, cnt_exp(2));

    // Dirty 0x440, then miss on 0x40 and abort WB with reset
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h440; cpu_wdata = 32'h0BADF00D;
    tick;
    cpu_we = 1'b0; cpu_addr = 32'h40;
    #1;
    chk("miss3_stall", {31'b0, cpu_stall}, 32'd1);
    tick;
    chk("wb3_req", {31'b0, mem_req}, 32'd1);
    chk("wb3_addr", mem_addr, 32'h440);
    chk("wb3_w0", mem_wdata[31:0], 32'h0BADF00D);
    reset = 1'b0;
    tick;
    chk("abort_req", {31'b0, mem_req}, 32'd0);
    chk("abort_stall", {31'b0, cpu_stall}, 32'd0);
    chk("abort_rdata", cpu_rdata, 32'd0);
    chk("abort_hit_cnt", hit_cnt, cnt_exp(0));
    chk("abort_miss_cnt", miss_cnt, cnt_exp(0));

    // Late ack after reset is ignored
    reset = 1'b1; cpu_req = 1'b0; mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    #1;
    chk("late_ack_req", {31'b0, mem_req}, 32'd0);

    // Cache invalidated: 0x40 misses and goes straight to FILL
    cpu_req = 1'b1; cpu_addr = 32'h40;
    #1;
    chk("post_rst_miss", {31'b0, cpu_stall}, 32'd1);
    tick;
    chk("post_rst_fill_we", {31'b0, mem_we}, 32'd0);
    chk("post_rst_fill_addr", mem_addr, 32'h40);
    chk("post_rst_miss_cnt", miss_cnt, cnt_exp(1));
    set_line(32'h55550000);
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    tick;
    chk("post_rst_rdata", cpu_rdata, 32'h55550000);
    chk("post_rst_stall", {31'b0, cpu_stall}, 32'd0);
    tick;
    cpu_req = 1'b0;
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- L1 data cache controller: direct-mapped, write-back, write-allocate.
- Sits between the MEM stage and off-chip data memory.
- Services MEM-stage loads/stores and drives cpu_stall, which freezes every pipeline register (MEM_WB included) while a miss is serviced.
- Talks to memory over a line-wide req/ack handshake.

Parameters:
- LINES, 32, number of cache lines (power of 2).
- INDEX_W, 5, log2(LINES).
- LINE_W, 256, line width in bits (8 x 32-bit words).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset (sampled on posedge clk; 0 = reset).
- cpu_req  in  1  MEM stage has a load or store this cycle.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  32  byte address; bits [1:0] ignored.
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data; valid when cpu_req && !cpu_we && !cpu_stall.
- cpu_stall  out  1  1 = hold the pipeline this cycle.
- mem_req  out  1  memory transfer request.
- mem_we  out  1  1 = line write-back, 0 = line fill.
- mem_addr  out  32  line-aligned address (bits [4:0] = 0).
- mem_wdata  out  LINE_W  victim line data.
- mem_rdata  in  LINE_W  fill data; valid when mem_ack = 1.
- mem_ack  in  1  one-cycle pulse: transfer complete.
- hit_cnt  out  32  hit counter (optional feature).
- miss_cnt  out  32  miss counter (optional feature).

Behaviour:
- Address split:
  - word offset = cpu_addr[4:2]
  - index = cpu_addr[INDEX_W+4:5]
  - tag = cpu_addr[31:INDEX_W+5]
- Per line storage: valid, dirty, tag, data.
- Hit = valid[index] && tag match.
- Reset (reset == 0 at posedge):
  - Clears all valid and dirty bits; state goes to IDLE.
  - Outputs: mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, counters = 0.
  - cpu_stall = 0 and cpu_rdata = 0 while reset is held.
  - Reset mid-transfer abandons the transfer; mem_req drops on the same edge. A late mem_ack is ignored.
- State IDLE:
  - cpu_req = 0: cpu_stall = 0.
  - Hit: cpu_stall = 0 (combinational).
    - Load: cpu_rdata = selected word, same cycle.
    - Store: word written and dirty set at the posedge.
  - Miss: cpu_stall = 1 in the same cycle.
    - Victim valid and dirty: go to WB.
    - Otherwise: go to FILL.
- State WB:
  - mem_req = 1, mem_we = 1, mem_addr = {victim tag, index, 5'b0}, mem_wdata = victim line.
  - Outputs stay stable until mem_ack.
  - On mem_ack: go to FILL.
- State FILL:
  - mem_req = 1, mem_we = 0, mem_addr = {cpu tag, index, 5'b0}.
  - On mem_ack: write mem_rdata into the line, set valid, clear dirty, go to DONE.
- State DONE:
  - cpu_stall = 1 for this cycle; go to IDLE.
  - In IDLE the replayed access hits and completes there.
- cpu_stall = 1 in WB, FILL and DONE regardless of cpu_req.
- cpu_addr, cpu_we and cpu_wdata must be held stable by the stalled pipeline throughout.
- mem_req is deasserted in the cycle after mem_ack.
- Minimum miss penalty: 2 cycles plus memory latency (clean), or 2 cycles plus two memory latencies (dirty).
- No new miss is accepted outside IDLE.
- Counters: +1 hit or +1 miss per IDLE cycle with cpu_req = 1.
  - A replayed access counts as a hit.
  - Counters wrap modulo 2^32.

Optional Feature:
- DCACHE_PERF_CNT_EN defined: hit_cnt and miss_cnt count as described above.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Package dcache_pkg holds:
  - state enum IDLE/WB/FILL/DONE (2 bits);
  - WORD_W = 32, OFFSET_W = 5, line-width constant;
  - address-field slice helper functions.
- Sub-module dcache_array: valid/dirty/tag/data storage with one read port and one write port (line fill or single-word write), synchronous clear on reset.

Test Plan:
- Reset, then load 0x00000040 with memory returning line word0 = 0xDEADBEEF → cpu_stall high, FILL with mem_addr = 0x40, DONE, then cpu_rdata = 0xDEADBEEF; miss_cnt = 1, hit_cnt = 1.
- Repeat the load at 0x40 → cpu_stall = 0, data same cycle, no mem_req.
- Store 0x12345678 to 0x44 (hit), then load 0x44 → 0x12345678 returned, line dirty.
- Load 0x00000440 (same index, new tag) after the dirty store → WB with mem_addr = 0x40 and word1 = 0x12345678, then FILL with mem_addr = 0x440.
- mem_ack delayed 10 cycles in FILL → mem_req and mem_addr held stable, cpu_stall held for all 10 cycles.
- reset = 0 asserted during WB → next cycle IDLE, mem_req = 0, all lines invalid; load 0x40 misses again.
